// File: rtl/dot_product_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_pkg
// Purpose  : Shared types and helpers for the dot-product engine: controller
//            state encoding, width helpers and the result saturation function.
// Revision : 1.0 - initial release
// ============================================================================
package dot_product_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Widest accumulator / return value the saturation helper can handle.
    localparam int ACC_MAX_W = 128;
    localparam int RET_MAX_W = 64;

    // Longest vector addressable with addr_w address bits.
    function automatic int len_max(input int addr_w);
        return 2 ** addr_w;
    endfunction

    // Accumulator width that can never overflow on a full-length sum.
    function automatic int acc_w_default(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

    typedef struct packed {
        logic                 ovf;
        logic [RET_MAX_W-1:0] val;
    } sat_t;

    // Clamp an accumulator (already sign/zero-extended to ACC_MAX_W by the
    // caller) into the ret_w-bit range of the selected signedness.  The
    // caller keeps the low ret_w bits of .val.
    function automatic sat_t sat_to_ret(input logic [ACC_MAX_W-1:0] acc,
                                        input logic                 signed_mode,
                                        input int                   ret_w);
        logic signed [ACC_MAX_W-1:0] s_acc;
        logic signed [ACC_MAX_W-1:0] one;
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        sat_t                        r;
        s_acc = $signed(acc);
        one   = {{(ACC_MAX_W-1){1'b0}}, 1'b1};
        if (signed_mode) begin
            hi = (one <<< (ret_w - 1)) - one;
            lo = -(one <<< (ret_w - 1));
        end else begin
            hi = (one <<< ret_w) - one;
            lo = '0;
        end
        r.ovf = 1'b0;
        r.val = s_acc[RET_MAX_W-1:0];
        if (s_acc > hi) begin
            r.ovf = 1'b1;
            r.val = hi[RET_MAX_W-1:0];
        end else if (s_acc < lo) begin
            r.ovf = 1'b1;
            r.val = lo[RET_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot_product_mac.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_mac
// Purpose  : Two-stage multiply-accumulate datapath: registers the product of
//            the current operand pair, then adds it into the accumulator one
//            cycle later.  clr_i empties the pipeline and zeroes the sum.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 38
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W:0]            w_a_ext;
    logic [DATA_W:0]            w_b_ext;
    logic signed [2*DATA_W+1:0] w_prod_full;
    logic                       w_prod_unused;
    logic [ACC_W-1:0]           w_prod_ext;

    logic [2*DATA_W-1:0]        prod_q;
    logic                       prod_vld_q;
    logic [ACC_W-1:0]           acc_q;

    // One extra bit per operand turns both signed and unsigned operands
    // into signed values, so a single signed multiplier serves both modes.
    assign w_a_ext     = {signed_i & a_i[DATA_W-1], a_i};
    assign w_b_ext     = {signed_i & b_i[DATA_W-1], b_i};
    assign w_prod_full = $signed(w_a_ext) * $signed(w_b_ext);
    // The true product always fits in 2*DATA_W bits in either mode.
    assign w_prod_unused = ^w_prod_full[2*DATA_W+1:2*DATA_W];

    assign w_prod_ext = {{(ACC_W-2*DATA_W){signed_i & prod_q[2*DATA_W-1]}}, prod_q};

    // Product stage followed by the accumulate stage.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= en_i;
            if (en_i) begin
                prod_q <= w_prod_full[2*DATA_W-1:0];
            end
            if (prod_vld_q) begin
                acc_q <= acc_q + w_prod_ext;
            end
        end
    end

    assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_engine
// Purpose  : Dot product of two vectors read from single-port memories, with
//            ap_ctrl_hs start/done/idle/ready handshake.  Per-run length and
//            signedness; result truncated to RET_W bits by default.
//            Build option DOT_PRODUCT_SAT_EN: saturate the result to the
//            RET_W range and raise ap_ovf when clamping occurred.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_engine
    import dot_product_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int ACC_W  = acc_w_default(DATA_W, ADDR_W),
    parameter int RET_W  = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ADDR_W:0]   len,
    input  logic              signed_mode,
    output logic [ADDR_W-1:0] a_address0,
    output logic              a_ce0,
    input  logic [DATA_W-1:0] a_q0,
    output logic [ADDR_W-1:0] b_address0,
    output logic              b_ce0,
    input  logic [DATA_W-1:0] b_q0,
    output logic [RET_W-1:0]  ap_return,
    output logic              ap_ovf
);

    localparam int              LEN_MAX   = len_max(ADDR_W);
    localparam logic [ADDR_W:0] C_LEN_MAX = (ADDR_W+1)'(LEN_MAX);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ce_q, ce_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              mode_q, mode_d;
    logic              rd_vld_q;
    logic [RET_W-1:0]  ret_q;
    logic              ovf_q;

    logic              w_start;
    logic [ACC_W-1:0]  w_acc;
    logic [RET_W-1:0]  w_result;
    logic              w_ovf;

    assign w_start = (state_q == ST_IDLE) && ap_start;

    // Next-state, read-address and run-parameter capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ce_d    = 1'b0;
        len_d   = len_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    len_d  = (len > C_LEN_MAX) ? C_LEN_MAX : len;
                    mode_d = signed_mode;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        ce_d    = 1'b1;
                        addr_d  = '0;
                    end
                end
            end
            ST_RUN: begin
                if ({1'b0, addr_q} == len_q - (ADDR_W+1)'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    ce_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Once no read data is in flight, only the final product is
                // left to accumulate, which happens on this same edge.
                if (!rd_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers plus the held result and overflow flag.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            ce_q     <= 1'b0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            ret_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ce_q     <= ce_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            rd_vld_q <= ce_q;
            if (state_q == ST_DONE) begin
                ret_q <= w_result;
                ovf_q <= w_ovf;
            end else if (w_start) begin
                ovf_q <= 1'b0;
            end
        end
    end

    dot_product_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .clr_i    (w_start),
        .en_i     (rd_vld_q),
        .signed_i (mode_q),
        .a_i      (a_q0),
        .b_i      (b_q0),
        .acc_o    (w_acc)
    );

`ifdef DOT_PRODUCT_SAT_EN
    logic [ACC_MAX_W-1:0] w_acc_ext;
    sat_t                 w_sat;

    assign w_acc_ext = {{(ACC_MAX_W-ACC_W){mode_q & w_acc[ACC_W-1]}}, w_acc};
    assign w_sat     = sat_to_ret(w_acc_ext, mode_q, RET_W);
    assign w_result  = w_sat.val[RET_W-1:0];
    assign w_ovf     = w_sat.ovf;

    generate
        if (RET_W < RET_MAX_W) begin : g_sat_hi
            logic w_sat_hi_unused;
            assign w_sat_hi_unused = ^w_sat.val[RET_MAX_W-1:RET_W];
        end
    endgenerate
`else
    assign w_result = w_acc[RET_W-1:0];
    assign w_ovf    = 1'b0;

    generate
        if (ACC_W > RET_W) begin : g_acc_hi
            logic w_acc_hi_unused;
            assign w_acc_hi_unused = ^w_acc[ACC_W-1:RET_W];
        end
    endgenerate
`endif

    // The final sum is only settled in DONE, so that cycle bypasses the
    // holding register; afterwards the register keeps it.
    assign ap_return  = (state_q == ST_DONE) ? w_result : ret_q;
    assign ap_ovf     = (state_q == ST_DONE) ? w_ovf : ovf_q;
    assign ap_done    = (state_q == ST_DONE);
    assign ap_ready   = (state_q == ST_DONE);
    assign ap_idle    = (state_q == ST_IDLE);
    assign a_ce0      = ce_q;
    assign b_ce0      = ce_q;
    assign a_address0 = addr_q;
    assign b_address0 = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_engine
// Purpose  : Self-checking bench for dot_product_engine: memory models, a
//            per-cycle behavioural reference and directed plus random runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_engine;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 6;
    localparam int RET_W   = 32;
    localparam int LEN_MAX = 64;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic              ap_start = 1'b0;
    logic              ap_done, ap_idle, ap_ready, ap_ovf;
    logic [ADDR_W:0]   len = '0;
    logic              signed_mode = 1'b0;
    logic [ADDR_W-1:0] a_address0, b_address0;
    logic              a_ce0, b_ce0;
    logic [DATA_W-1:0] a_q0 = '0, b_q0 = '0;
    logic [RET_W-1:0]  ap_return;

    logic [DATA_W-1:0] mem_a [LEN_MAX];
    logic [DATA_W-1:0] mem_b [LEN_MAX];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    dot_product_engine dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .len         (len),
        .signed_mode (signed_mode),
        .a_address0  (a_address0),
        .a_ce0       (a_ce0),
        .a_q0        (a_q0),
        .b_address0  (b_address0),
        .b_ce0       (b_ce0),
        .b_q0        (b_q0),
        .ap_return   (ap_return),
        .ap_ovf      (ap_ovf)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Synchronous-read memories; output garbage when not enabled.
    always @(posedge ap_clk) begin
        a_q0 <= a_ce0 ? mem_a[a_address0] : DATA_W'($urandom);
        b_q0 <= b_ce0 ? mem_b[b_address0] : DATA_W'($urandom);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Dot product from the arithmetic definition, then fitted to RET_W.
    function automatic void model_result(input int L, input bit md,
                                         output logic [31:0] r, output logic o);
        longint s = 0;
        for (int i = 0; i < L; i++) begin
            if (md) s += longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
            else    s += longint'(mem_a[i]) * longint'(mem_b[i]);
        end
        o = 1'b0;
        r = s[31:0];
`ifdef DOT_PRODUCT_SAT_EN
        if (md) begin
            if (s > 64'sd2147483647)       begin r = 32'h7FFF_FFFF; o = 1'b1; end
            else if (s < -64'sd2147483648) begin r = 32'h8000_0000; o = 1'b1; end
        end else if (s > 64'sd4294967295) begin
            r = 32'hFFFF_FFFF; o = 1'b1;
        end
`endif
    endfunction

    // Reference model state.
    bit          m_valid = 0;
    bit          m_busy  = 0;
    int          m_t0    = 0;
    int          m_len   = 0;
    logic [31:0] m_res   = '0;
    logic        m_res_ovf = 1'b0;
    logic [31:0] m_ret   = '0;
    logic        m_ovf   = 1'b0;
    int          m_addr  = 0;

    // Per-cycle comparison against the reference, then reference update.
    always @(negedge ap_clk) begin
        int   k;
        logic e_ce, e_done, e_idle, e_ovf;
        logic [31:0] e_ret;
        e_done = 1'b0;
        if (m_valid) begin
            if (m_busy) begin
                k      = cyc - m_t0;
                e_ce   = (m_len > 0) && (k >= 1) && (k <= m_len);
                if (e_ce) m_addr = k - 1;
                e_done = (m_len == 0) ? (k == 1) : (k == m_len + 3);
                e_idle = 1'b0;
                e_ret  = e_done ? m_res : m_ret;
                e_ovf  = e_done ? m_res_ovf : 1'b0;
            end else begin
                e_ce = 1'b0; e_idle = 1'b1; e_ret = m_ret; e_ovf = m_ovf;
            end
            chk("ap_done",    ap_done,    e_done);
            chk("ap_ready",   ap_ready,   e_done);
            chk("ap_idle",    ap_idle,    e_idle);
            chk("a_ce0",      a_ce0,      e_ce);
            chk("b_ce0",      b_ce0,      e_ce);
            chk("a_address0", a_address0, m_addr);
            chk("b_address0", b_address0, m_addr);
            chk("ap_return",  ap_return,  e_ret);
            chk("ap_ovf",     ap_ovf,     e_ovf);
        end
        if (ap_rst) begin
            m_valid = 1; m_busy = 0; m_ret = '0; m_ovf = 1'b0; m_addr = 0;
        end else if (m_valid) begin
            if (m_busy && e_done) begin
                m_busy = 0; m_ret = m_res; m_ovf = m_res_ovf;
            end else if (!m_busy && ap_start) begin
                m_busy = 1;
                m_t0   = cyc;
                m_len  = (int'(len) > LEN_MAX) ? LEN_MAX : int'(len);
                m_ovf  = 1'b0;
                model_result(m_len, signed_mode, m_res, m_res_ovf);
            end
        end
    end

    // One run: start pulse, optional input churn while busy, wait for done.
    task automatic run_once(input int ln, input bit md, input bit jitter,
                            output int done_k, output logic [31:0] r,
                            output logic o, output int ce_cnt);
        int lc;
        lc = (ln > LEN_MAX) ? LEN_MAX : ln;
        done_k = -1; ce_cnt = 0; r = '0; o = 1'b0;
        @(posedge ap_clk); #1;
        ap_start = 1'b1; len = (ADDR_W+1)'(ln); signed_mode = md;
        for (int k = 0; k < 300 && done_k < 0; k++) begin
            @(negedge ap_clk);
            if (a_ce0) ce_cnt++;
            if (ap_done) begin done_k = k; r = ap_return; o = ap_ovf; end
            @(posedge ap_clk); #1;
            if (jitter && (k + 1 <= lc)) begin
                ap_start = 1'($urandom); len = (ADDR_W+1)'($urandom); signed_mode = 1'($urandom);
            end else begin
                ap_start = 1'b0;
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < LEN_MAX; i++) begin
            mem_a[i] = DATA_W'(i);
            mem_b[i] = DATA_W'(2 * i);
        end
    endtask

    initial begin
        int          dk, cc, dn, idle_cnt, idle_at;
        logic [31:0] r;
        logic        o;
        int          done_at [2];

        #200000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          dk, cc, dn, idle_cnt, idle_at, rl;
        logic [31:0] r;
        logic        o;
        bit          md;

        fill_ramp();
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_idle",   ap_idle,    1'b1);
        chk("rst_done",   ap_done,    1'b0);
        chk("rst_ce",     a_ce0,      1'b0);
        chk("rst_addr",   a_address0, 0);
        chk("rst_return", ap_return,  0);

        // Unsigned ramp: sum of 2*i^2 for i<16.
        run_once(16, 1'b0, 1'b0, dk, r, o, cc);
        chk("ramp_return", r, 2480);
        chk("ramp_done_cycle", dk, 19);
        chk("ramp_ce_cycles", cc, 16);

        // -1 times i, signed then unsigned.
        for (int i = 0; i < LEN_MAX; i++) begin mem_a[i] = 16'hFFFF; mem_b[i] = DATA_W'(i); end
        run_once(16, 1'b1, 1'b0, dk, r, o, cc);
        chk("signed_return", r, 32'hFFFF_FF88);
        run_once(16, 1'b0, 1'b0, dk, r, o, cc);
        chk("unsigned_return", r, 7864200);

        // Zero-length run.
        run_once(0, 1'b0, 1'b0, dk, r, o, cc);
        chk("len0_done_cycle", dk, 1);
        chk("len0_return", r, 0);
        chk("len0_ce_cycles", cc, 0);

        // Full-length sum that exceeds 32 bits.
        for (int i = 0; i < LEN_MAX; i++) begin mem_a[i] = 16'h7FFF; mem_b[i] = 16'h7FFF; end
        run_once(64, 1'b0, 1'b0, dk, r, o, cc);
`ifdef DOT_PRODUCT_SAT_EN
        chk("big_return", r, 32'hFFFF_FFFF);
        chk("big_ovf", o, 1'b1);
`else
        chk("big_return", r, 32'hFFC0_0040);
        chk("big_ovf", o, 1'b0);
`endif
        chk("big_done_cycle", dk, 67);

        // Back-to-back runs with ap_start held high.
        fill_ramp();
        @(posedge ap_clk); #1;
        ap_start = 1'b1; len = 7'd16; signed_mode = 1'b0;
        dn = 0; idle_cnt = 0; idle_at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                chk("b2b_return", ap_return, 2480);
                chk("b2b_done_cycle", k, (dn == 0) ? 19 : 39);
                dn++;
            end
            if (k >= 1 && ap_idle) begin idle_cnt++; idle_at = k; end
            @(posedge ap_clk); #1;
            if (k == 39) ap_start = 1'b0;
        end
        chk("b2b_done_count", dn, 2);
        chk("b2b_idle_count", idle_cnt, 1);
        chk("b2b_idle_cycle", idle_at, 20);

        // Reset during a run.
        @(posedge ap_clk); #1;
        ap_start = 1'b1; len = 7'd16;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (4) @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        @(posedge ap_clk); #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("abort_ce", a_ce0, 1'b0);
        chk("abort_idle", ap_idle, 1'b1);
        chk("abort_return", ap_return, 0);
        dn = 0;
        repeat (25) begin @(negedge ap_clk); if (ap_done) dn++; end
        chk("abort_no_done", dn, 0);
        run_once(16, 1'b0, 1'b0, dk, r, o, cc);
        chk("after_abort_return", r, 2480);

        // Random runs; lengths beyond LEN_MAX exercise the clamp.
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < LEN_MAX; i++) begin
                mem_a[i] = DATA_W'($urandom);
                mem_b[i] = DATA_W'($urandom);
            end
            rl = (t == 0) ? 127 : int'($urandom_range(0, 100));
            md = 1'($urandom);
            run_once(rl, md, 1'b1, dk, r, o, cc);
            chk("rand_done_cycle", dk, (rl == 0) ? 1 : (((rl > LEN_MAX) ? LEN_MAX : rl) + 3));
            repeat ($urandom_range(0, 3)) @(posedge ap_clk);
        end

        repeat (3) @(posedge ap_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
